detect_read_sequencer: RTL and testbench

Sequences 128-bit period words from the detection input FIFO into the detection datapath, one word at a time with valid/ready backpressure. Tags each word with its period index, line index and processing phase, and steps the phase from background-noise accumulation (BG) to threshold initialisation (INIT) to object detection (RUN) on line boundaries. It sits between the line FIFO and the background-noise, abs-sum and object-tracking logic, which no longer count periods or lines themselves.

---
 rtl/detect_pkg.sv | 18 +
 rtl/detect_pos_counter.sv | 109 ++++++++++
 rtl/detect_read_sequencer.sv | 128 ++++++++++++
 tb/tb_detect_read_sequencer.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/detect_pkg.sv
// Shared detection constants: datapath word width, default period count and phase encoding.
package detect_pkg;

  localparam int DETECT_DATA_W     = 128;
  localparam int DETECT_PERIOD_NUM = 21;

  typedef logic [1:0] phase_t;

  localparam phase_t PH_BG   = 2'd0;
  localparam phase_t PH_INIT = 2'd1;
  localparam phase_t PH_RUN  = 2'd2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_READ = 1'b1
  } rd_state_e;

endpackage

// File: rtl/detect_pos_counter.sv
// Period/line/phase position counters with deferred restart; advance on each accepted beat.
// DETECT_SEQ_DEBUG_EN exposes the live period and line counters.
module detect_pos_counter
  import detect_pkg::*;
#(
  parameter int PERIOD_NUM = DETECT_PERIOD_NUM,
  parameter int BG_LINES   = 8,
  parameter int INIT_LINES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        advance,
  input  logic        restart,
  input  logic        beat_held,
`ifdef DETECT_SEQ_DEBUG_EN
  output logic [7:0]  period,
  output logic [15:0] line,
`endif
  output logic [7:0]  period_nx,
  output logic [15:0] line_nx,
  output phase_t      phase_nx,
  output logic        bg_done,
  output logic        init_done
);

  localparam logic [7:0]  LAST_PERIOD = 8'(PERIOD_NUM - 1);
  localparam logic [15:0] LAST_BG     = 16'(BG_LINES - 1);
  localparam logic [15:0] LAST_INIT   = 16'(INIT_LINES - 1);

`ifndef DETECT_SEQ_DEBUG_EN
  logic [7:0]  period;
  logic [15:0] line;
`endif
  phase_t phase;
  logic   restart_pend;
  logic   pend_nx;
  logic   bg_done_nx;
  logic   init_done_nx;

  // NOTE: every always_comb output is given a default first so no path can infer a latch.
  always_comb begin
    period_nx    = period;
    line_nx      = line;
    phase_nx     = phase;
    pend_nx      = restart_pend | restart;
    bg_done_nx   = 1'b0;
    init_done_nx = 1'b0;
    if (advance) begin
      if (period == LAST_PERIOD) begin
        period_nx = '0;
        if (pend_nx) begin
          // A pending restart replaces the normal line/phase step and suppresses done pulses.
          phase_nx = PH_BG;
          line_nx  = '0;
          pend_nx  = 1'b0;
        end else begin
          case (phase)
            PH_BG: begin
              if (line == LAST_BG) begin
                phase_nx   = PH_INIT;
                line_nx    = '0;
                bg_done_nx = 1'b1;
              end else begin
                line_nx = line + 16'd1;
              end
            end
            PH_INIT: begin
              if (line == LAST_INIT) begin
                phase_nx     = PH_RUN;
                line_nx      = '0;
                init_done_nx = 1'b1;
              end else begin
                line_nx = line + 16'd1;
              end
            end
            default: line_nx = line + 16'd1;
          endcase
        end
      end else begin
        period_nx = period + 8'd1;
      end
    end else if (restart && (period == 8'd0) && !beat_held) begin
      // Already on a line boundary: restart applies immediately.
      phase_nx = PH_BG;
      line_nx  = '0;
      pend_nx  = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      period       <= '0;
      line         <= '0;
      phase        <= PH_BG;
      restart_pend <= 1'b0;
      bg_done      <= 1'b0;
      init_done    <= 1'b0;
    end else begin
      period       <= period_nx;
      line         <= line_nx;
      phase        <= phase_nx;
      restart_pend <= pend_nx;
      bg_done      <= bg_done_nx;
      init_done    <= init_done_nx;
    end
  end

endmodule

// File: rtl/detect_read_sequencer.sv
// Reads period words from the line FIFO one at a time and presents them tagged with period/line/phase.
// Optional debug ports are enabled with DETECT_SEQ_DEBUG_EN.
module detect_read_sequencer
  import detect_pkg::*;
#(
  parameter int PERIOD_NUM = DETECT_PERIOD_NUM,
  parameter int BG_LINES   = 8,
  parameter int INIT_LINES = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     enable,
  input  logic                     restart,
  input  logic [DETECT_DATA_W-1:0] rddata,
  input  logic                     rdempty,
  output logic                     rdfifo,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DETECT_DATA_W-1:0] out_data,
  output logic [7:0]               out_period,
  output logic [15:0]              out_line,
  output logic [1:0]               out_phase,
  output logic                     out_sol,
  output logic                     out_eol,
  output logic                     bg_done,
`ifdef DETECT_SEQ_DEBUG_EN
  output logic                     init_done,
  output logic [0:0]               dbg_state,
  output logic [7:0]               dbg_period,
  output logic [15:0]              dbg_line,
  output logic [31:0]              dbg_rd_count
`else
  output logic                     init_done
`endif
);

  localparam logic [7:0] LAST_PERIOD = 8'(PERIOD_NUM - 1);

  rd_state_e   state;
  rd_state_e   state_nx;
  logic        accept;
  logic        load;
  logic [7:0]  period_nx;
  logic [15:0] line_nx;
  phase_t      phase_nx;

  assign accept = out_valid && out_ready;
  assign load   = (state == ST_READ);

  always_comb begin
    state_nx = state;
    rdfifo   = 1'b0;
    case (state)
      ST_IDLE: begin
        // Gated by reset so no FIFO word is popped while the block is being cleared.
        if (!reset && enable && !rdempty && (!out_valid || out_ready)) begin
          rdfifo   = 1'b1;
          state_nx = ST_READ;
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_period <= '0;
      out_line   <= '0;
      out_phase  <= PH_BG;
      out_sol    <= 1'b0;
      out_eol    <= 1'b0;
    end else begin
      state <= state_nx;
      if (load) begin
        // Tags come from the post-accept counter values so a same-cycle accept is accounted for.
        out_valid  <= 1'b1;
        out_data   <= rddata;
        out_period <= period_nx;
        out_line   <= line_nx;
        out_phase  <= phase_nx;
        out_sol    <= (period_nx == 8'd0);
        out_eol    <= (period_nx == LAST_PERIOD);
      end else if (accept) begin
        out_valid <= 1'b0;
      end
    end
  end

  detect_pos_counter #(
    .PERIOD_NUM (PERIOD_NUM),
    .BG_LINES   (BG_LINES),
    .INIT_LINES (INIT_LINES)
  ) u_pos (
    .clk       (clk),
    .reset     (reset),
    .advance   (accept),
    .restart   (restart),
    .beat_held (out_valid),
`ifdef DETECT_SEQ_DEBUG_EN
    .period    (dbg_period),
    .line      (dbg_line),
`endif
    .period_nx (period_nx),
    .line_nx   (line_nx),
    .phase_nx  (phase_nx),
    .bg_done   (bg_done),
    .init_done (init_done)
  );

`ifdef DETECT_SEQ_DEBUG_EN
  logic [31:0] rd_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_count <= '0;
    end else if (rdfifo) begin
      rd_count <= rd_count + 32'd1;
    end
  end

  assign dbg_state    = (state == ST_READ);
  assign dbg_rd_count = rd_count;
`endif

endmodule

// File: tb/tb_detect_read_sequencer.sv
// Self-checking bench for detect_read_sequencer: randomized FIFO data and handshakes against a
// cycle-level behavioural model of the read/tag/phase rules.
module tb_detect_read_sequencer;

  localparam int PN  = 21;
  localparam int BGL = 2;
  localparam int INL = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         enable;
  logic         restart;
  logic [127:0] rddata;
  logic         rdempty;
  logic         rdfifo;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic [7:0]   out_period;
  logic [15:0]  out_line;
  logic [1:0]   out_phase;
  logic         out_sol;
  logic         out_eol;
  logic         bg_done;
  logic         init_done;

  always #5 clk = ~clk;

  detect_read_sequencer #(
    .PERIOD_NUM (PN),
    .BG_LINES   (BGL),
    .INIT_LINES (INL)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .restart    (restart),
    .rddata     (rddata),
    .rdempty    (rdempty),
    .rdfifo     (rdfifo),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_period (out_period),
    .out_line   (out_line),
    .out_phase  (out_phase),
    .out_sol    (out_sol),
    .out_eol    (out_eol),
    .bg_done    (bg_done),
    .init_done  (init_done)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: position of the beat currently held / next to be presented.
  int           m_period, m_line, m_phase;
  bit           m_pend, m_valid, m_inflight, m_bgp, m_initp;
  logic [127:0] m_data, word;

  int n_beats, rd_cnt, rd_empty_hits, bg_at, init_at, done_cnt;
  int log_phase [2048];
  int log_line  [2048];
  int log_period[2048];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs are already set; compare, update the model, return at the next negedge.
  task automatic cyc();
    bit exp_rd, acc, bgp, initp;
    if (m_inflight) begin
      word   = {$urandom, $urandom, $urandom, $urandom};
      rddata = word;
    end
    #1;
    bgp   = 1'b0;
    initp = 1'b0;
    if (reset) begin
      m_valid    = 1'b0;
      m_inflight = 1'b0;
      m_pend     = 1'b0;
      m_period   = 0;
      m_line     = 0;
      m_phase    = 0;
    end else begin
      exp_rd = !m_inflight && enable && !rdempty && (!m_valid || out_ready);
      chk("rdfifo", rdfifo, exp_rd);
      chk("out_valid", out_valid, m_valid);
      chk("bg_done", bg_done, m_bgp);
      chk("init_done", init_done, m_initp);
      if (m_valid) begin
        chk("out_data", out_data, m_data);
        chk("out_period", out_period, 128'(m_period));
        chk("out_line", out_line, 128'(m_line));
        chk("out_phase", out_phase, 128'(m_phase));
        chk("out_sol", out_sol, m_period == 0);
        chk("out_eol", out_eol, m_period == PN - 1);
      end
      if (rdfifo) rd_cnt++;
      if (rdfifo && rdempty) rd_empty_hits++;
      if (bg_done) bg_at = n_beats;
      if (init_done) init_at = n_beats;
      if (bg_done || init_done) done_cnt++;

      acc = m_valid && out_ready;
      if (restart) m_pend = 1'b1;
      if (acc) begin
        if (n_beats < 2048) begin
          log_phase[n_beats]  = int'(out_phase);
          log_line[n_beats]   = int'(out_line);
          log_period[n_beats] = int'(out_period);
        end
        n_beats++;
        if (m_period == PN - 1) begin
          m_period = 0;
          if (m_pend) begin
            m_phase = 0;
            m_line  = 0;
            m_pend  = 1'b0;
          end else begin
            m_line++;
            if (m_phase == 0 && m_line == BGL) begin
              m_phase = 1;
              m_line  = 0;
              bgp     = 1'b1;
            end else if (m_phase == 1 && m_line == INL) begin
              m_phase = 2;
              m_line  = 0;
              initp   = 1'b1;
            end else if (m_line == 65536) begin
              m_line = 0;
            end
          end
        end else begin
          m_period++;
        end
      end else if (restart && m_period == 0 && !m_valid) begin
        m_phase = 0;
        m_line  = 0;
        m_pend  = 1'b0;
      end
      if (m_inflight) begin
        m_valid = 1'b1;
        m_data  = word;
      end else if (acc) begin
        m_valid = 1'b0;
      end
      m_inflight = exp_rd;
    end
    @(posedge clk);
    @(negedge clk);
    m_bgp   = bgp;
    m_initp = initp;
  endtask

  task automatic chk_reset_outputs(input string pfx);
    #1;
    chk({pfx, "_rdfifo"}, rdfifo, 1'b0);
    chk({pfx, "_valid"}, out_valid, 1'b0);
    chk({pfx, "_data"}, out_data, 128'd0);
    chk({pfx, "_period"}, out_period, 128'd0);
    chk({pfx, "_line"}, out_line, 128'd0);
    chk({pfx, "_phase"}, out_phase, 128'd0);
    chk({pfx, "_sol"}, out_sol, 1'b0);
    chk({pfx, "_eol"}, out_eol, 1'b0);
    chk({pfx, "_bg_done"}, bg_done, 1'b0);
    chk({pfx, "_init_done"}, init_done, 1'b0);
  endtask

  initial begin
    int rbase, b0, bad;
    reset = 1'b1; enable = 1'b0; restart = 1'b0; rdempty = 1'b1; out_ready = 1'b0; rddata = '0;
    m_period = 0; m_line = 0; m_phase = 0; m_pend = 0; m_valid = 0; m_inflight = 0;
    m_bgp = 0; m_initp = 0; m_data = '0; word = '0;
    n_beats = 0; rd_cnt = 0; rd_empty_hits = 0; bg_at = -1; init_at = -1; done_cnt = 0;

    // Reset state
    @(negedge clk);
    cyc();
    cyc();
    reset = 1'b0;
    chk_reset_outputs("rst");

    // Full-rate streaming through BG -> INIT -> RUN
    enable = 1'b1; rdempty = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 400 && n_beats < 64; i++) cyc();
    chk("stream_beats", n_beats >= 64, 1'b1);
    chk("beat0_phase", 128'(log_phase[0]), 128'd0);
    chk("beat41_phase", 128'(log_phase[41]), 128'd0);
    chk("beat41_line", 128'(log_line[41]), 128'd1);
    chk("beat41_period", 128'(log_period[41]), 128'd20);
    chk("beat42_phase", 128'(log_phase[42]), 128'd1);
    chk("beat62_phase", 128'(log_phase[62]), 128'd1);
    chk("beat63_phase", 128'(log_phase[63]), 128'd2);
    chk("beat63_line", 128'(log_line[63]), 128'd0);
    chk("bg_done_after", 128'(bg_at), 128'd42);
    chk("init_done_after", 128'(init_at), 128'd63);
    rd_cnt = 0;
    repeat (20) cyc();
    chk("rd_every_other", 128'(rd_cnt), 128'd10);

    // Backpressure for 5 cycles with a beat held
    for (int i = 0; i < 10 && !m_valid; i++) cyc();
    out_ready = 1'b0;
    rd_cnt = 0;
    repeat (5) cyc();
    chk("hold_no_rd", 128'(rd_cnt), 128'd0);
    chk("hold_data", out_data, m_data);
    out_ready = 1'b1;
    repeat (6) cyc();

    // rdempty toggling every cycle
    rd_empty_hits = 0;
    b0 = n_beats;
    for (int i = 0; i < 40; i++) begin
      rdempty = (i % 2 == 0);
      cyc();
    end
    rdempty = 1'b0;
    bad = 0;
    for (int k = b0; k + 1 < n_beats && k + 1 < 2048; k++)
      if (log_period[k + 1] != (log_period[k] + 1) % PN) bad++;
    chk("empty_no_rd", 128'(rd_empty_hits), 128'd0);
    chk("empty_contig", 128'(bad), 128'd0);
    chk("empty_progress", n_beats > b0, 1'b1);

    // Randomized handshakes, enable, empty and occasional restart
    for (int i = 0; i < 300; i++) begin
      enable    = ($urandom_range(0, 3) != 0);
      rdempty   = ($urandom_range(0, 3) == 0);
      out_ready = ($urandom_range(0, 1) == 1);
      restart   = ($urandom_range(0, 63) == 0);
      cyc();
    end
    restart = 1'b0;

    // Restart at period 7 of RUN line 3
    reset = 1'b1; enable = 1'b0;
    cyc();
    reset = 1'b0; enable = 1'b1; rdempty = 1'b0; out_ready = 1'b1;
    n_beats = 0;
    for (int i = 0; i < 2000 && !(m_valid && m_phase == 2 && m_line == 3 && m_period == 7); i++) cyc();
    chk("reach_run_l3_p7", m_valid && m_phase == 2 && m_line == 3 && m_period == 7, 1'b1);
    rbase = n_beats;
    done_cnt = 0;
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    for (int i = 0; i < 100 && n_beats < rbase + 15; i++) cyc();
    chk("rs_p7_phase", 128'(log_phase[rbase]), 128'd2);
    chk("rs_p7_period", 128'(log_period[rbase]), 128'd7);
    chk("rs_p20_phase", 128'(log_phase[rbase + 13]), 128'd2);
    chk("rs_p20_period", 128'(log_period[rbase + 13]), 128'd20);
    chk("rs_next_phase", 128'(log_phase[rbase + 14]), 128'd0);
    chk("rs_next_line", 128'(log_line[rbase + 14]), 128'd0);
    chk("rs_next_period", 128'(log_period[rbase + 14]), 128'd0);
    chk("rs_no_done", 128'(done_cnt), 128'd0);

    // enable drops the cycle after rdfifo
    for (int i = 0; i < 10 && !m_inflight; i++) cyc();
    enable = 1'b0;
    rd_cnt = 0;
    b0 = n_beats;
    repeat (8) cyc();
    chk("en_drop_no_rd", 128'(rd_cnt), 128'd0);
    chk("en_drop_delivered", 128'(n_beats - b0), 128'd1);
    enable = 1'b1;
    repeat (4) cyc();

    // Reset while a read is in flight
    for (int i = 0; i < 10 && !m_inflight; i++) cyc();
    reset = 1'b1; enable = 1'b0;
    cyc();
    reset = 1'b0;
    chk_reset_outputs("rst_read");
    enable = 1'b1;
    b0 = n_beats;
    for (int i = 0; i < 20 && n_beats == b0; i++) cyc();
    chk("post_rst_beat", n_beats > b0, 1'b1);
    chk("post_rst_period", 128'(log_period[b0]), 128'd0);
    chk("post_rst_line", 128'(log_line[b0]), 128'd0);
    chk("post_rst_phase", 128'(log_phase[b0]), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
